// File: rtl/adv_dpll_pid_if.sv
// Signal bundle between the DPLL servo and its environment.
// Clock and reset stay as plain ports on the servo itself.
interface adv_dpll_pid_if;
  logic               ref_pulse;
  logic               feedback_pulse;
  logic signed [47:0] phase_error_in;
  logic               phase_error_valid;
  logic        [31:0] kp;
  logic        [31:0] ki;
  logic        [31:0] kd;
  logic               loop_enable;
  logic signed [47:0] phase_error_out;
  logic signed [47:0] frequency_correction;
  logic               dpll_locked;
  logic        [31:0] allan_deviation;
  logic        [31:0] mtie;
  logic               pid_saturated;

  modport master (
    output ref_pulse, feedback_pulse, phase_error_in, phase_error_valid, kp, ki, kd, loop_enable,
    input  phase_error_out, frequency_correction, dpll_locked, allan_deviation, mtie, pid_saturated
  );

  modport slave (
    input  ref_pulse, feedback_pulse, phase_error_in, phase_error_valid, kp, ki, kd, loop_enable,
    output phase_error_out, frequency_correction, dpll_locked, allan_deviation, mtie, pid_saturated
  );
endinterface

// File: rtl/adv_dpll_pid.sv
// PPS digital PLL servo: phase detector, Q16.16 PID, lock detect, Allan/MTIE metrics.
// A sample accepted at edge N shows on phase_error_out after N, all PID/metric outputs after N+1.
module adv_dpll_pid #(
  parameter int unsigned        CLK_FREQ_HZ = 100_000_000,
  parameter logic signed [47:0] LOCK_THRESH = 48'sd1310720,
  parameter int unsigned        LOCK_COUNT  = 8,
  parameter logic signed [47:0] INT_LIMIT   = 48'sh0FFF_FFFF_FFFF,
  parameter logic signed [47:0] OUT_LIMIT   = 48'sh0FFF_FFFF_FFFF,
  parameter int unsigned        ADEV_SHIFT  = 4
) (
  input logic           clk,
  input logic           rst,
  adv_dpll_pid_if.slave bus
);
  localparam logic [31:0] HALF_WIN = 32'(CLK_FREQ_HZ / 2);
  localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);

  logic               ref_d, fb_d, ref_rise, fb_rise, ref_armed;
  logic        [31:0] cyc_cnt, ts_ref, span;
  logic               det_valid;
  logic signed [47:0] det_e;
  logic               s1_v;
  logic signed [47:0] s1_e;

  logic signed [47:0] e_prev, e_prev2, integ, max_q, min_q;
  logic        [LCW-1:0] lock_cnt, lk_new;
  logic        [1:0]  seen;
  logic        [51:0] adev_q, adev_new, d2;

  logic signed [79:0] e80, ep80, ip80, kp80, ki80, kd80, p80, d80;
  logic signed [79:0] i_raw, i_new80, o_raw, ilim80, olim80;
  logic signed [47:0] i_new, o_new;
  logic               i_sat, o_sat;
  logic signed [52:0] a_e, a_p, a_p2, a_d, a_d2, a_cur, a_delta;
  logic        [49:0] e_abs, thr_lo, thr_hi;
  logic signed [47:0] mx_new, mn_new;
  logic signed [48:0] mx49, mn49, span49;
  logic        [31:0] mtie_new, adev_out;

  assign ref_rise = bus.ref_pulse & ~ref_d;
  assign fb_rise  = bus.feedback_pulse & ~fb_d;

  // Phase detector: same-cycle edges count as zero span since ref is taken first.
  always_comb begin
    span      = ref_rise ? 32'd0 : (cyc_cnt - ts_ref);
    det_valid = fb_rise & (ref_rise | ref_armed) & (span <= HALF_WIN);
    det_e     = {span, 16'd0};
  end

  // Edge history, free-running timestamp counter and ref arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_d     <= 1'b0;
      fb_d      <= 1'b0;
      cyc_cnt   <= '0;
      ts_ref    <= '0;
      ref_armed <= 1'b0;
    end else begin
      ref_d   <= bus.ref_pulse;
      fb_d    <= bus.feedback_pulse;
      cyc_cnt <= cyc_cnt + 32'd1;
      if (ref_rise) ts_ref <= cyc_cnt;
      // A feedback edge consumes the armed ref even if the span is out of window.
      if (fb_rise && (ref_rise || ref_armed)) ref_armed <= 1'b0;
      else if (ref_rise)                      ref_armed <= 1'b1;
    end
  end

  // Sample select: external strobe wins over the internal detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v                <= 1'b0;
      s1_e                <= '0;
      bus.phase_error_out <= '0;
    end else begin
      s1_v <= bus.phase_error_valid | det_valid;
      if (bus.phase_error_valid || det_valid) begin
        s1_e                <= bus.phase_error_valid ? bus.phase_error_in : det_e;
        bus.phase_error_out <= bus.phase_error_valid ? bus.phase_error_in : det_e;
      end
    end
  end

  // PID, lock and stability math for the staged sample.
  always_comb begin
    e80    = {{32{s1_e[47]}}, s1_e};
    ep80   = {{32{e_prev[47]}}, e_prev};
    ip80   = {{32{integ[47]}}, integ};
    kp80   = {48'd0, bus.kp};
    ki80   = {48'd0, bus.ki};
    kd80   = {48'd0, bus.kd};
    ilim80 = {32'd0, INT_LIMIT};
    olim80 = {32'd0, OUT_LIMIT};
    p80    = (kp80 * e80) >>> 16;
    d80    = (kd80 * (e80 - ep80)) >>> 16;
    i_raw  = ip80 + ((ki80 * e80) >>> 16);
    i_sat  = 1'b1;
    if (i_raw > ilim80)       i_new = INT_LIMIT;
    else if (i_raw < -ilim80) i_new = -INT_LIMIT;
    else begin
      i_new = i_raw[47:0];
      i_sat = 1'b0;
    end
    i_new80 = {{32{i_new[47]}}, i_new};
    o_raw   = p80 + i_new80 + d80;
    o_sat   = 1'b1;
    if (o_raw > olim80)       o_new = OUT_LIMIT;
    else if (o_raw < -olim80) o_new = -OUT_LIMIT;
    else begin
      o_new = o_raw[47:0];
      o_sat = 1'b0;
    end

    a_e    = {{5{s1_e[47]}}, s1_e};
    a_p    = {{5{e_prev[47]}}, e_prev};
    a_p2   = {{5{e_prev2[47]}}, e_prev2};
    e_abs  = s1_e[47] ? 50'(-a_e) : 50'(a_e);
    thr_lo = 50'(LOCK_THRESH);
    thr_hi = thr_lo << 1;
    lk_new = lock_cnt;
    if (e_abs < thr_lo) begin
      if (lock_cnt < LCW'(LOCK_COUNT)) lk_new = lock_cnt + 1'b1;
    end else if (e_abs >= thr_hi) begin
      lk_new = '0;
    end

    a_d      = a_e - (a_p <<< 1) + a_p2;
    d2       = a_d[52] ? 52'(-a_d) : 52'(a_d);
    a_d2     = {1'b0, d2};
    a_cur    = {1'b0, adev_q};
    a_delta  = a_d2 - a_cur;
    adev_new = 52'(a_cur + (a_delta >>> ADEV_SHIFT));
    adev_out = (adev_new > 52'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : adev_new[31:0];

    mx_new   = (seen == 2'd0 || s1_e > max_q) ? s1_e : max_q;
    mn_new   = (seen == 2'd0 || s1_e < min_q) ? s1_e : min_q;
    mx49     = {mx_new[47], mx_new};
    mn49     = {mn_new[47], mn_new};
    span49   = mx49 - mn49;
    mtie_new = (span49 > 49'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : span49[31:0];
  end

  // Commit results only when a staged sample is present; otherwise everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_prev                   <= '0;
      e_prev2                  <= '0;
      integ                    <= '0;
      lock_cnt                 <= '0;
      seen                     <= '0;
      adev_q                   <= '0;
      max_q                    <= '0;
      min_q                    <= '0;
      bus.frequency_correction <= '0;
      bus.pid_saturated        <= 1'b0;
      bus.dpll_locked          <= 1'b0;
      bus.allan_deviation      <= '0;
      bus.mtie                 <= '0;
    end else if (s1_v) begin
      e_prev          <= s1_e;
      e_prev2         <= e_prev;
      lock_cnt        <= lk_new;
      bus.dpll_locked <= (lk_new == LCW'(LOCK_COUNT));
      if (seen != 2'd3) seen <= seen + 2'd1;
      if (seen >= 2'd2) begin
        adev_q              <= adev_new;
        bus.allan_deviation <= adev_out;
      end
      max_q    <= mx_new;
      min_q    <= mn_new;
      bus.mtie <= mtie_new;
      if (bus.loop_enable) begin
        integ                    <= i_new;
        bus.frequency_correction <= o_new;
        bus.pid_saturated        <= i_sat | o_sat;
      end else begin
        integ                    <= '0;
        bus.frequency_correction <= '0;
        bus.pid_saturated        <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adv_dpll_pid.sv
// Bench for adv_dpll_pid: directed table, detector sequences, lock/saturation corners,
// then randomized samples against an arithmetic reference model.
module tb_adv_dpll_pid;
  localparam logic signed [127:0] LIM   = 128'sh0FFF_FFFF_FFFF;
  localparam logic signed [127:0] THR   = 128'sd1310720;
  localparam logic signed [127:0] MAX32 = 128'sh0_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adv_dpll_pid_if bus ();
  adv_dpll_pid dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: full sample history plus integrator and lock count.
  logic signed [47:0]  m_hist[$];
  logic signed [127:0] m_i, m_corr, m_adev, m_adev_out, m_mtie;
  logic                m_sat, m_locked;
  int                  m_lock;

  typedef struct {
    logic signed [47:0] e;
    logic [31:0]        kp, ki, kd;
    logic signed [47:0] corr;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [127:0] clampv(input logic signed [127:0] x, output logic s);
    s = 1'b1;
    if (x > LIM) return LIM;
    if (x < -LIM) return -LIM;
    s = 1'b0;
    return x;
  endfunction

  function automatic logic signed [127:0] absv(input logic signed [127:0] x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_i = 0; m_corr = 0; m_adev = 0; m_adev_out = 0; m_mtie = 0;
    m_sat = 0; m_locked = 0; m_lock = 0;
  endtask

  task automatic model_update(input logic signed [47:0] e);
    logic signed [127:0] x, ep, ep2, p, d, mx, mn, d2;
    logic si, so;
    x   = e;
    ep  = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : 48'sd0;
    ep2 = (m_hist.size() > 1) ? m_hist[m_hist.size()-2] : 48'sd0;
    p   = ($signed({96'd0, bus.kp}) * x) >>> 16;
    d   = ($signed({96'd0, bus.kd}) * (x - ep)) >>> 16;
    if (bus.loop_enable) begin
      m_i    = clampv(m_i + (($signed({96'd0, bus.ki}) * x) >>> 16), si);
      m_corr = clampv(p + m_i + d, so);
      m_sat  = si | so;
    end else begin
      m_i = 0; m_corr = 0; m_sat = 0;
    end
    m_hist.push_back(e);
    if (absv(x) < THR) m_lock = (m_lock < 8) ? m_lock + 1 : 8;
    else if (absv(x) >= 2 * THR) m_lock = 0;
    m_locked = (m_lock == 8);
    if (m_hist.size() >= 3) begin
      d2         = absv(x - 2 * ep + ep2);
      m_adev     = m_adev + ((d2 - m_adev) >>> 4);
      m_adev_out = (m_adev > MAX32) ? MAX32 : m_adev;
    end
    mx = m_hist[0];
    mn = m_hist[0];
    foreach (m_hist[k]) begin
      if (m_hist[k] > mx) mx = m_hist[k];
      if (m_hist[k] < mn) mn = m_hist[k];
    end
    m_mtie = ((mx - mn) > MAX32) ? MAX32 : (mx - mn);
  endtask

  // Entered at the falling edge right after the accepting rising edge.
  task automatic finish_sample(input logic signed [47:0] e);
    chk("phase_error_out", bus.phase_error_out, e);
    model_update(e);
    @(negedge clk);
    chk("frequency_correction", bus.frequency_correction, m_corr[63:0]);
    chk("pid_saturated", bus.pid_saturated, m_sat);
    chk("dpll_locked", bus.dpll_locked, m_locked);
    chk("allan_deviation", bus.allan_deviation, m_adev_out[63:0]);
    chk("mtie", bus.mtie, m_mtie[63:0]);
  endtask

  task automatic ext_sample(input logic signed [47:0] e);
    bus.phase_error_valid = 1'b1;
    bus.phase_error_in    = e;
    @(negedge clk);
    bus.phase_error_valid = 1'b0;
    finish_sample(e);
  endtask

  task automatic int_sample(input int gap);
    logic signed [47:0] e;
    e = 48'(gap) <<< 16;
    if (gap == 0) begin
      bus.ref_pulse = 1'b1;
      bus.feedback_pulse = 1'b1;
      @(negedge clk);
      bus.ref_pulse = 1'b0;
      bus.feedback_pulse = 1'b0;
    end else begin
      bus.ref_pulse = 1'b1;
      @(negedge clk);
      bus.ref_pulse = 1'b0;
      repeat (gap - 1) @(negedge clk);
      bus.feedback_pulse = 1'b1;
      @(negedge clk);
      bus.feedback_pulse = 1'b0;
    end
    finish_sample(e);
  endtask

  task automatic set_gains(input logic [31:0] p, input logic [31:0] i, input logic [31:0] d,
                           input logic en);
    bus.kp = p; bus.ki = i; bus.kd = d; bus.loop_enable = en;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ref_pulse = 1'b0; bus.feedback_pulse = 1'b0;
    bus.phase_error_valid = 1'b0; bus.phase_error_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] r;
    logic signed [45:0] big;
    logic signed [47:0] e;

    vecs[0] = '{48'sd327680,  32'h10000, 32'h1000, 32'h800, 48'sd358400};
    vecs[1] = '{48'sd327680,  32'h10000, 32'h1000, 32'h800, 48'sd368640};
    vecs[2] = '{48'sd0,       32'h10000, 32'h1000, 32'h800, 48'sd30720};
    vecs[3] = '{-48'sd327680, 32'h10000, 32'h1000, 32'h800, -48'sd317440};

    set_gains(32'h0, 32'h0, 32'h0, 1'b1);
    do_reset();
    chk("rst phase_error_out", bus.phase_error_out, 64'sd0);
    chk("rst frequency_correction", bus.frequency_correction, 64'sd0);
    chk("rst dpll_locked", bus.dpll_locked, 64'sd0);
    chk("rst allan_deviation", bus.allan_deviation, 64'sd0);
    chk("rst mtie", bus.mtie, 64'sd0);
    chk("rst pid_saturated", bus.pid_saturated, 64'sd0);

    // Directed PID table.
    for (int v = 0; v < 4; v++) begin
      set_gains(vecs[v].kp, vecs[v].ki, vecs[v].kd, 1'b1);
      ext_sample(vecs[v].e);
      chk("vec correction", bus.frequency_correction, vecs[v].corr);
    end

    // Internal detector: 7-cycle span, stray feedback, coincident edges, strobe priority.
    do_reset();
    set_gains(32'h10000, 32'h0, 32'h0, 1'b1);
    int_sample(7);
    chk("detector 7 cycles", bus.phase_error_out, 64'sd458752);
    bus.feedback_pulse = 1'b1;
    @(negedge clk);
    bus.feedback_pulse = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray feedback ignored", bus.phase_error_out, 64'sd458752);
    chk("stray feedback hold", bus.frequency_correction, m_corr[63:0]);
    int_sample(0);
    bus.ref_pulse = 1'b1;
    @(negedge clk);
    bus.ref_pulse = 1'b0;
    repeat (2) @(negedge clk);
    bus.feedback_pulse = 1'b1;
    bus.phase_error_valid = 1'b1;
    bus.phase_error_in = 48'sd589824;
    @(negedge clk);
    bus.feedback_pulse = 1'b0;
    bus.phase_error_valid = 1'b0;
    finish_sample(48'sd589824);

    // Lock acquisition then loss on a large error.
    do_reset();
    set_gains(32'h0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) ext_sample(48'sd65536);
    chk("locked after 8", bus.dpll_locked, 64'sd1);
    ext_sample(48'sd2686976);
    chk("unlock on big error", bus.dpll_locked, 64'sd0);
    chk("mtie 40", bus.mtie, 64'sd2621440);

    // Output clamp, then loop disable.
    set_gains(32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
    ext_sample(48'sh4000_0000_0000);
    chk("clamp correction", bus.frequency_correction, 64'sh0FFF_FFFF_FFFF);
    chk("clamp saturated", bus.pid_saturated, 64'sd1);
    set_gains(32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    ext_sample(48'sd65536);
    chk("disabled correction", bus.frequency_correction, 64'sd0);
    chk("disabled saturated", bus.pid_saturated, 64'sd0);

    // Randomized samples against the model.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        set_gains($urandom, $urandom, $urandom, 1'($urandom_range(0, 7) != 0));
      else
        set_gains($urandom_range(0, 32'h40000), $urandom_range(0, 32'h8000),
                  $urandom_range(0, 32'h8000), 1'($urandom_range(0, 7) != 0));
      case ($urandom_range(0, 5))
        0: begin
          r = {$urandom, $urandom};
          big = r[45:0];
          ext_sample(48'(big));
        end
        1: int_sample(int'($urandom_range(0, 20)));
        default: begin
          e = 48'($urandom_range(0, 60 * 65536)) - 48'sd1966080;
          ext_sample(e);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("idle hold", bus.frequency_correction, m_corr[63:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
